// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared state encoding and defaults for input-conditioning
//                blocks (debouncer FSM states, synchronizer depth).
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

    // Bit 1 of the state is the debounced level; bit 0 marks a pending change.
    localparam logic [1:0] STABLE_LOW  = 2'b00;
    localparam logic [1:0] PEND_HIGH   = 2'b01;
    localparam logic [1:0] STABLE_HIGH = 2'b10;
    localparam logic [1:0] PEND_LOW    = 2'b11;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Multi-flop synchronizer for an asynchronous single-bit input,
//                synchronous active-high reset to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("sync_chain: STAGES must be at least 1");
        end

        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_sync[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce
//  Description : Synchronizes and debounces a raw asynchronous input into a
//                clean registered level, with a qualification-busy flag.
//  Revision    : 1.0  initial release
// ============================================================================
module input_debounce
    import debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam bit               c_SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic             w_in_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_busy;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_debounce: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("input_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (w_in_s)
    );

    // The sample that opens a PEND_* state counts as the first agreeing one,
    // so the count leaves STABLE_* at 1 and accepts on reaching DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                STABLE_LOW: begin
                    if (w_in_s) begin
                        if (c_SINGLE) begin
                            r_state <= STABLE_HIGH;
                            r_out   <= 1'b1;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= PEND_HIGH;
                            r_cnt   <= c_CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end

                PEND_HIGH: begin
                    if (w_in_s) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= STABLE_HIGH;
                            r_out   <= 1'b1;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                STABLE_HIGH: begin
                    if (!w_in_s) begin
                        if (c_SINGLE) begin
                            r_state <= STABLE_LOW;
                            r_out   <= 1'b0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= PEND_LOW;
                            r_cnt   <= c_CNT_ONE;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end

                PEND_LOW: begin
                    if (!w_in_s) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= STABLE_LOW;
                            r_out   <= 1'b0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;

endmodule : input_debounce
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debounce
//  Description : Self-checking bench for input_debounce across three parameter
//                sets, against a run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_debounce;

    localparam int N_DUT  = 3;
    localparam int LOG_SZ = 65536;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_raw = 1'b1;
    logic [N_DUT-1:0] out_v;
    logic [N_DUT-1:0] busy_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    input_debounce u_dut_a (
        .clk(clk), .reset(reset), .in(in_raw), .out(out_v[0]), .busy(busy_v[0])
    );
    input_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut_b (
        .clk(clk), .reset(reset), .in(in_raw), .out(out_v[1]), .busy(busy_v[1])
    );
    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut_c (
        .clk(clk), .reset(reset), .in(in_raw), .out(out_v[2]), .busy(busy_v[2])
    );

    function automatic int sync_of(input int k);
        return (k == 1) ? 3 : 2;
    endfunction

    function automatic int dc_of(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the level seen by the debouncer at edge n is the raw
    // input sampled SYNC edges earlier (0 if a reset edge intervened); the
    // output flips once DC consecutive samples disagree with it.
    bit in_log [0:LOG_SZ-1];
    int edge_n   = 0;
    int last_rst = 0;
    bit m_out [N_DUT];
    int m_run [N_DUT];

    always @(posedge clk) begin
        in_log[edge_n % LOG_SZ] = in_raw;
        if (reset) begin
            last_rst = edge_n;
            for (int k = 0; k < N_DUT; k++) begin
                m_out[k] = 1'b0;
                m_run[k] = 0;
            end
        end else begin
            for (int k = 0; k < N_DUT; k++) begin
                bit ins;
                ins = (edge_n - sync_of(k) > last_rst) ? in_log[(edge_n - sync_of(k)) % LOG_SZ] : 1'b0;
                if (ins != m_out[k]) m_run[k] = m_run[k] + 1;
                else                 m_run[k] = 0;
                if (m_run[k] == dc_of(k)) begin
                    m_out[k] = ~m_out[k];
                    m_run[k] = 0;
                end
            end
        end
        edge_n++;
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check_eq($sformatf("out%0d", k), {31'd0, out_v[k]}, {31'd0, m_out[k]});
            check_eq($sformatf("busy%0d", k), {31'd0, busy_v[k]}, {31'd0, (m_run[k] != 0)});
        end
    end

    // Counts edges from the current input change until each DUT shows lvl.
    task automatic measure(input logic lvl, output int lat_a, output int busy_a,
                           output int lat_b, output int busy_b_cnt);
        lat_a = -1; busy_a = -1; lat_b = -1; busy_b_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (busy_a < 0 && busy_v[0]) busy_a = i;
            if (busy_v[1]) busy_b_cnt++;
            if (lat_b < 0 && out_v[1] == lvl) lat_b = i;
            if (out_v[0] == lvl) begin
                lat_a = i;
                break;
            end
        end
    endtask

    task automatic pulse_window(input int width, input int window,
                                output int out_hi, output int busy_hi);
        out_hi = 0; busy_hi = 0;
        in_raw = 1'b1;
        for (int i = 0; i < window; i++) begin
            if (i == width) in_raw = 1'b0;
            @(posedge clk);
            #1;
            if (out_v[0])  out_hi++;
            if (busy_v[0]) busy_hi++;
        end
        @(negedge clk);
    endtask

    initial begin
        int la, ba, lb, bb, oh, bh;
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held 3 cycles with input high, then release.
        reset  = 1'b1;
        in_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        measure(1'b1, la, ba, lb, bb);
        check_eq("rst_rel_lat_a", la, 18);
        check_eq("rst_rel_busy_a", ba, 3);
        check_eq("rst_rel_lat_b", lb, 4);
        check_eq("rst_rel_busy_b", bb, 0);
        @(negedge clk);

        // Clean step back to low.
        repeat (5) @(negedge clk);
        in_raw = 1'b0;
        measure(1'b0, la, ba, lb, bb);
        check_eq("step_low_lat_a", la, 18);
        check_eq("step_low_busy_a", ba, 3);
        check_eq("step_low_lat_b", lb, 4);
        @(negedge clk);
        repeat (25) @(negedge clk);

        // Bounce then steady high: latency counts from the final rise.
        for (int i = 0; i < 5; i++) begin
            in_raw = pat[i];
            @(negedge clk);
        end
        in_raw = pat[5];
        measure(1'b1, la, ba, lb, bb);
        check_eq("bounce_lat_a", la, 18);
        @(negedge clk);
        in_raw = 1'b0;
        repeat (30) @(negedge clk);

        // Glitches of 15 and 16 samples.
        pulse_window(15, 60, oh, bh);
        check_eq("glitch15_out_hi", oh, 0);
        check_eq("glitch15_busy_seen", {31'd0, (bh != 0)}, 1);
        repeat (5) @(negedge clk);
        pulse_window(16, 60, oh, bh);
        check_eq("pulse16_out_hi", oh, 16);
        repeat (5) @(negedge clk);

        // Reset while qualifying a rise with the count at 10.
        in_raw = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_out", {31'd0, out_v[0]}, 0);
        check_eq("rst_mid_busy", {31'd0, busy_v[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        measure(1'b1, la, ba, lb, bb);
        check_eq("rst_mid_relat_a", la, 18);
        @(negedge clk);

        // Randomized segments with occasional resets.
        for (int s = 0; s < 300; s++) begin
            int len;
            in_raw = 1'($urandom_range(0, 1));
            len    = $urandom_range(1, 24);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat (len) @(negedge clk);
        end

        // Fast toggling keeps the long-window output constant.
        in_raw = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            in_raw = ~in_raw;
            @(negedge clk);
        end
        check_eq("toggle_hold_a", {31'd0, out_v[0]}, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_input_debounce
`default_nettype wire
